axis_frame_arb: RTL
===================

AXIS_FRAME_ARB -- requirements
Module: axis_frame_arb

Interface
REQ-001 SHALL have parameter DW, default 32, stream data width in bits.
REQ-002 SHALL have parameter NS, default 2, number of source streams; legal range 2..4.
REQ-003 SHALL have port ACLK  in  1  clock; all logic is on its rising edge.
REQ-004 SHALL have port ARESET  in  1  reset; one clock domain, synchronous, active-high.
REQ-005 SHALL have port cfg_en  in  1  arbiter enable; when 0, no new frame is granted.
REQ-006 SHALL have port cfg_lines  in  12  lines per frame (TLAST count); 0 is treated as 1.
REQ-007 SHALL have ports s_tdata/s_tkeep/s_tlast/s_tuser/s_tvalid  in  NS*DW/NS*4/NS/NS/NS  source streams, packed with source i at slice i.
REQ-008 SHALL have port s_tready  out  NS  per-source ready.
REQ-009 SHALL have ports m_tdata/m_tkeep/m_tlast/m_tuser/m_tvalid  out  DW/4/1/1/1  merged stream; m_tready  in  1.
REQ-010 SHALL have port st_grant  out  2  index of the current or last granted source.
REQ-011 SHALL have port st_busy  out  1  high while in PASS.
REQ-012 SHALL have port st_frames  out  16  count of completed frames, wrapping.

Function
REQ-013 SHALL use video stream semantics: TUSER=1 on a beat marks start of frame (SOF); TLAST=1 marks end of line; a transfer is TVALID&TREADY.
REQ-014 SHALL implement states ARB and PASS; the reset state is ARB.
REQ-015 In ARB, SHALL hold an SOF beat pending on any source (s_tready=0) and discard its non-SOF beats (s_tready=1), which flushes partial frames.
REQ-016 In ARB with cfg_en=1, SHALL grant round-robin among sources with s_tvalid&s_tuser, starting after the last grant, and enter PASS on the next cycle.
REQ-017 In PASS, SHALL combinationally connect the granted source to m_* (zero latency) and drive s_tready[grant]=m_tready.
REQ-018 In PASS, SHALL drive s_tready=0 for non-granted sources.
REQ-019 In ARB, SHALL hold m_tvalid=0.
REQ-020 In PASS, SHALL count TLAST transfers; on the transfer that makes the count equal max(cfg_lines,1), it SHALL return to ARB next cycle and increment st_frames.
REQ-021 SHALL keep a SOF beat that arrives in PASS mid-frame on the granted source and pass it through without restarting the line count.
REQ-022 SHALL let cfg_en=0 during PASS finish the current frame, then idle in ARB.
REQ-023 SHALL sample cfg_lines at grant time; changes during PASS do not affect the current frame.
REQ-024 SHALL drive st_busy=1 exactly while in PASS.

Reset
REQ-025 ARESET SHALL force the following reset values: state ARB, round-robin pointer so that source 0 has priority, line counter 0, st_grant 0, st_frames 0, m_tvalid 0, and s_tready = discard behaviour per REQ-015.
REQ-026 ARESET asserted mid-frame SHALL abort the frame immediately with no st_frames increment.

Configuration
REQ-027 With macro AXIS_FRAME_ARB_STATS_EN defined, SHALL add output st_drops (NS*16 bits, wrapping), counting discarded beats per source in ARB, reset to 0.
REQ-028 Without AXIS_FRAME_ARB_STATS_EN, SHALL omit st_drops and its counters entirely.

Structure
REQ-029 SHALL take the state enum, the cfg_lines width constant (12) and the NS maximum (4) from a shared package axis_frame_arb_pkg.
REQ-030 SHALL place the round-robin grant logic in sub-module rr_arbiter (inputs: request vector and last grant; output: one-hot grant).

Verification
REQ-031 Scenario: NS=2, cfg_lines=2, both sources present SOF together after reset -> source 0 frame passes (2 TLAST), then source 1; st_frames=2.
REQ-032 Scenario: source 1 sends 3 non-SOF beats while in ARB -> all 3 accepted and none appear on m_*; with STATS_EN, st_drops[1]=3.
REQ-033 Scenario: m_tready toggles 1/0 each cycle during PASS -> m_* beats identical and in order, no loss or duplication.
REQ-034 Scenario: cfg_en cleared mid-frame -> frame completes, then m_tvalid stays 0 while SOFs wait held with s_tready=0.
REQ-035 Scenario: ARESET pulsed after 1 of 2 lines -> next cycle state ARB, m_tvalid=0, st_frames unchanged at 0.
REQ-036 Scenario: cfg_lines=0 -> frame ends after the first TLAST transfer.

Source files
------------

// File: rtl/axis_frame_arb_pkg.sv
// Shared types and constants for the axis_frame_arb frame arbiter.
package axis_frame_arb_pkg;

    localparam int CFG_LINES_W = 12;
    localparam int NS_MAX      = 4;
    localparam int GRANT_W     = 2;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    // A programmed line count of zero still means a one-line frame.
    function automatic logic [CFG_LINES_W-1:0] eff_lines(input logic [CFG_LINES_W-1:0] lines);
        return (lines == '0) ? CFG_LINES_W'(1) : lines;
    endfunction

endpackage

// File: rtl/axis_frame_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after last_i.
module rr_arbiter
    import axis_frame_arb_pkg::*;
#(
    parameter int NS = 2
) (
    input  logic [NS-1:0]      req_i,
    input  logic [GRANT_W-1:0] last_i,
    output logic [NS-1:0]      gnt_o
);

    logic found;

    // Visit sources at rotating offsets 1..NS from the last grant; first hit wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int off = 1; off <= NS; off++) begin
            for (int i = 0; i < NS; i++) begin
                if (!found && req_i[i] && (i == ((int'(last_i) + off) % NS))) begin
                    gnt_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axis_frame_arb.sv
// Frame-level AXI-Stream video arbiter: merges NS sources, one whole frame at a time.
// Optional per-source discard counters enabled by macro AXIS_FRAME_ARB_STATS_EN.
module axis_frame_arb
    import axis_frame_arb_pkg::*;
#(
    parameter int DW = 32,
    parameter int NS = 2
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   cfg_en,
    input  logic [CFG_LINES_W-1:0] cfg_lines,
    input  logic [NS*DW-1:0]       s_tdata,
    input  logic [NS*4-1:0]        s_tkeep,
    input  logic [NS-1:0]          s_tlast,
    input  logic [NS-1:0]          s_tuser,
    input  logic [NS-1:0]          s_tvalid,
    output logic [NS-1:0]          s_tready,
    output logic [DW-1:0]          m_tdata,
    output logic [3:0]             m_tkeep,
    output logic                   m_tlast,
    output logic                   m_tuser,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [GRANT_W-1:0]     st_grant,
    output logic                   st_busy,
`ifdef AXIS_FRAME_ARB_STATS_EN
    output logic [NS*16-1:0]       st_drops,
`endif
    output logic [15:0]            st_frames
);

    // Handshake: a beat moves when valid and ready are both high on a rising
    // edge; valid never depends on ready, and in PASS ready follows m_tready.

    state_t                 state_q, state_d;
    logic [GRANT_W-1:0]     grant_q, grant_d;
    logic [GRANT_W-1:0]     last_q, last_d;
    logic [CFG_LINES_W-1:0] lines_q, lines_d;
    logic [CFG_LINES_W-1:0] cnt_q, cnt_d;
    logic [15:0]            frames_q, frames_d;

    logic [NS-1:0]          sof_req;
    logic [NS-1:0]          win_oh;
    logic [GRANT_W-1:0]     win_idx;

    logic [DW-1:0]          sel_data;
    logic [3:0]             sel_keep;
    logic                   sel_last;
    logic                   sel_user;
    logic                   sel_valid;

    assign sof_req = s_tvalid & s_tuser;

    rr_arbiter #(.NS(NS)) u_rr (
        .req_i  (sof_req),
        .last_i (last_q),
        .gnt_o  (win_oh)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NS; i++) begin
            if (win_oh[i]) win_idx = GRANT_W'(i);
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                sel_data  = s_tdata[i*DW +: DW];
                sel_keep  = s_tkeep[i*4 +: 4];
                sel_last  = s_tlast[i];
                sel_user  = s_tuser[i];
                sel_valid = s_tvalid[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        lines_d  = lines_q;
        cnt_d    = cnt_q;
        frames_d = frames_q;
        s_tready = '0;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;
        m_tvalid = 1'b0;

        case (state_q)
            ST_ARB: begin
                // SOF beats wait for a grant; anything else is a stale partial frame.
                s_tready = ~s_tuser;
                if (cfg_en && (|sof_req)) begin
                    state_d = ST_PASS;
                    grant_d = win_idx;
                    last_d  = win_idx;
                    lines_d = eff_lines(cfg_lines);
                    cnt_d   = '0;
                end
            end
            ST_PASS: begin
                m_tdata  = sel_data;
                m_tkeep  = sel_keep;
                m_tlast  = sel_last;
                m_tuser  = sel_user;
                m_tvalid = sel_valid;
                for (int i = 0; i < NS; i++) begin
                    if (grant_q == GRANT_W'(i)) s_tready[i] = m_tready;
                end
                if (sel_valid && m_tready && sel_last) begin
                    if (cnt_q + 1'b1 == lines_q) begin
                        state_d  = ST_ARB;
                        cnt_d    = '0;
                        frames_d = frames_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= ST_ARB;
            grant_q  <= '0;
            last_q   <= GRANT_W'(NS - 1);
            lines_q  <= CFG_LINES_W'(1);
            cnt_q    <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            lines_q  <= lines_d;
            cnt_q    <= cnt_d;
            frames_q <= frames_d;
        end
    end

    assign st_grant  = grant_q;
    assign st_busy   = (state_q == ST_PASS);
    assign st_frames = frames_q;

`ifdef AXIS_FRAME_ARB_STATS_EN
    logic [15:0] drops_q [NS];

    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NS; i++) begin
            if (ARESET) begin
                drops_q[i] <= '0;
            end else if (state_q == ST_ARB && s_tvalid[i] && !s_tuser[i]) begin
                drops_q[i] <= drops_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        st_drops = '0;
        for (int i = 0; i < NS; i++) begin
            st_drops[i*16 +: 16] = drops_q[i];
        end
    end
`endif

endmodule
